// File: rtl/neureka_col_accumulator.sv
// Column partial-result accumulator: sums a programmed number of signed beats from the
// binconv column and hands one final (optionally saturated) sum to the normalisation stage.
module neureka_col_accumulator #(
  parameter int unsigned IN_WIDTH  = 24,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned LEN_WIDTH = 16,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  output logic                 start_ready_o,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 pres_valid_i,
  input  logic [IN_WIDTH-1:0]  pres_data_i,
  output logic                 pres_ready_o,
  output logic                 acc_valid_o,
  output logic [ACC_WIDTH-1:0] acc_data_o,
  input  logic                 acc_ready_i,
  output logic                 ovf_o,
  output logic                 done_o,
  output logic                 busy_o
);

  generate
    if (ACC_WIDTH < IN_WIDTH) begin : g_bad_width
      $error("neureka_col_accumulator: ACC_WIDTH must be >= IN_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

  state_e                       state_r, state_nx_s;
  logic signed [ACC_WIDTH-1:0]  acc_r, acc_nx_s;
  logic        [LEN_WIDTH-1:0]  cnt_r, cnt_nx_s;
  logic        [LEN_WIDTH-1:0]  len_r, len_nx_s;
  logic                         ovf_r, ovf_nx_s;
  logic signed [IN_WIDTH-1:0]   pres_s;
  logic signed [ACC_WIDTH-1:0]  pres_ext_s;
  logic signed [ACC_WIDTH-1:0]  add_res_s;
  logic                         add_ovf_s;
  logic                         kill_s;
  logic                         pres_hs_s;

  // Signed add returning {overflow, result}; on overflow the result either wraps or
  // clamps toward the sign of the operands, so later beats continue from the clamp.
  function automatic logic [ACC_WIDTH:0] acc_add(input logic signed [ACC_WIDTH-1:0] a,
                                                 input logic signed [ACC_WIDTH-1:0] b);
    logic signed [ACC_WIDTH-1:0] s;
    logic                        o;
    s = a + b;
    o = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
    if (o && SATURATE) begin
      s = a[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      s = s;
    end
    return {o, s};
  endfunction

  assign pres_s                 = pres_data_i;
  assign pres_ext_s             = ACC_WIDTH'(pres_s);
  assign {add_ovf_s, add_res_s} = acc_add(acc_r, pres_ext_s);

  // A reset or clear cycle must not complete any handshake.
  assign kill_s        = rst_i | clear_i;
  assign start_ready_o = (state_r == ST_IDLE);
  assign pres_ready_o  = (state_r == ST_ACCUM) && !kill_s;
  assign acc_valid_o   = (state_r == ST_OUTPUT) && !kill_s;
  assign acc_data_o    = (state_r == ST_OUTPUT) ? acc_r : {ACC_WIDTH{1'b0}};
  assign done_o        = acc_valid_o && acc_ready_i;
  assign busy_o        = (state_r != ST_IDLE);
  assign ovf_o         = ovf_r;
  assign pres_hs_s     = pres_valid_i && pres_ready_o;

  // Next-state and datapath update for the job sequencer.
  always_comb begin
    state_nx_s = state_r;
    acc_nx_s   = acc_r;
    cnt_nx_s   = cnt_r;
    len_nx_s   = len_r;
    ovf_nx_s   = ovf_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          acc_nx_s = {ACC_WIDTH{1'b0}};
          cnt_nx_s = {LEN_WIDTH{1'b0}};
          ovf_nx_s = 1'b0;
          len_nx_s = len_i;
          if (len_i != {LEN_WIDTH{1'b0}}) begin
            state_nx_s = ST_ACCUM;
          end else begin
            state_nx_s = ST_OUTPUT;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (pres_hs_s) begin
          acc_nx_s = add_res_s;
          ovf_nx_s = ovf_r | add_ovf_s;
          cnt_nx_s = cnt_r + LEN_WIDTH'(1);
          if (cnt_r == len_r - LEN_WIDTH'(1)) begin
            state_nx_s = ST_OUTPUT;
          end else begin
            state_nx_s = ST_ACCUM;
          end
        end else begin
          state_nx_s = ST_ACCUM;
        end
      end
      ST_OUTPUT: begin
        if (acc_ready_i) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_OUTPUT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; clear_i aborts exactly like reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_r <= ST_IDLE;
      acc_r   <= {ACC_WIDTH{1'b0}};
      cnt_r   <= {LEN_WIDTH{1'b0}};
      len_r   <= {LEN_WIDTH{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      acc_r   <= acc_nx_s;
      cnt_r   <= cnt_nx_s;
      len_r   <= len_nx_s;
      ovf_r   <= ovf_nx_s;
    end
  end

endmodule

// File: tb/tb_neureka_col_accumulator.sv
// Bench for neureka_col_accumulator: one 24->32 bit wrapping instance plus 8->8 bit
// wrapping and saturating instances, all driven by the same control stream.
module tb_neureka_col_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clear, start, pres_valid, acc_ready;
  logic [15:0] len_in;
  logic [23:0] pres_data;
  logic [7:0]  pres_data8;

  logic        sr_m, pr_m, av_m, ovf_m, done_m, busy_m;
  logic [31:0] ad_m;
  logic        sr_w, pr_w, av_w, ovf_w, done_w, busy_w;
  logic [7:0]  ad_w;
  logic        sr_s, pr_s, av_s, ovf_s, done_s, busy_s;
  logic [7:0]  ad_s;

  neureka_col_accumulator #(.IN_WIDTH(24), .ACC_WIDTH(32), .LEN_WIDTH(16), .SATURATE(1'b0)) u_main (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .start_ready_o(sr_m),
    .len_i(len_in), .pres_valid_i(pres_valid), .pres_data_i(pres_data), .pres_ready_o(pr_m),
    .acc_valid_o(av_m), .acc_data_o(ad_m), .acc_ready_i(acc_ready), .ovf_o(ovf_m),
    .done_o(done_m), .busy_o(busy_m));

  neureka_col_accumulator #(.IN_WIDTH(8), .ACC_WIDTH(8), .LEN_WIDTH(16), .SATURATE(1'b0)) u_wrap8 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .start_ready_o(sr_w),
    .len_i(len_in), .pres_valid_i(pres_valid), .pres_data_i(pres_data8), .pres_ready_o(pr_w),
    .acc_valid_o(av_w), .acc_data_o(ad_w), .acc_ready_i(acc_ready), .ovf_o(ovf_w),
    .done_o(done_w), .busy_o(busy_w));

  neureka_col_accumulator #(.IN_WIDTH(8), .ACC_WIDTH(8), .LEN_WIDTH(16), .SATURATE(1'b1)) u_sat8 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .start_ready_o(sr_s),
    .len_i(len_in), .pres_valid_i(pres_valid), .pres_data_i(pres_data8), .pres_ready_o(pr_s),
    .acc_valid_o(av_s), .acc_data_o(ad_s), .acc_ready_i(acc_ready), .ovf_o(ovf_s),
    .done_o(done_s), .busy_o(busy_s));

  int errors = 0;
  int checks = 0;
  logic signed [23:0] beats [0:511];

  typedef struct {
    int     len;
    int     d [4];
    bit     gap;
    int     stall;
    bit     hold;
    longint e32; bit o32;
    longint e8w; bit o8w;
    longint e8s; bit o8s;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: running sum in wide arithmetic, then wrap or clamp into w bits.
  function automatic void model(input int w, input bit sat, input int len,
                                output longint sum, output bit ovf);
    longint acc, v, s, mx, mn;
    acc = 0;
    ovf = 1'b0;
    mx  = (64'sd1 <<< (w - 1)) - 1;
    mn  = -(64'sd1 <<< (w - 1));
    for (int i = 0; i < len; i++) begin
      if (w == 8) v = longint'($signed(beats[i][7:0]));
      else        v = longint'(beats[i]);
      s = acc + v;
      if (s > mx || s < mn) begin
        ovf = 1'b1;
        if (sat) s = (s > mx) ? mx : mn;
        else     s = (s > mx) ? s - (mx - mn + 1) : s + (mx - mn + 1);
      end
      acc = s;
    end
    sum = acc;
  endfunction

  task automatic check_idle(input string nm);
    chk({nm, ".start_ready"}, {sr_m, sr_w, sr_s}, 3'b111);
    chk({nm, ".pres_ready"},  {pr_m, pr_w, pr_s}, 3'b000);
    chk({nm, ".acc_valid"},   {av_m, av_w, av_s}, 3'b000);
    chk({nm, ".acc_data"},    {ad_m, ad_w, ad_s}, 48'd0);
    chk({nm, ".done"},        {done_m, done_w, done_s}, 3'b000);
    chk({nm, ".busy"},        {busy_m, busy_w, busy_s}, 3'b000);
  endtask

  // Runs one job; entered and left just after a falling edge.
  task automatic job(input int len, input bit gap, input int stall, input bit hold,
                     input longint e32, input bit o32, input longint e8w, input bit o8w,
                     input longint e8s, input bit o8s, input string nm);
    int idx, cyc;
    bit hs;
    start  = 1'b1;
    len_in = len[15:0];
    #1;
    chk({nm, ".start_ready"}, sr_m, 1);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    #1;
    chk({nm, ".busy"}, {busy_m, busy_w, busy_s}, 3'b111);
    idx = 0;
    cyc = 0;
    while (idx < len) begin
      pres_valid = gap ? (cyc % 2 == 0) : 1'b1;
      pres_data  = beats[idx];
      pres_data8 = beats[idx][7:0];
      #1;
      hs = pres_valid && pr_m;
      @(posedge clk); @(negedge clk);
      if (hs) idx++;
      cyc++;
      if (cyc > 4 * len + 8) begin
        chk({nm, ".beat_timeout"}, idx, len);
        break;
      end
    end
    // Offer junk while the sum is pending: it must not be taken.
    pres_valid = 1'b1;
    pres_data  = 24'h5A5A5A;
    pres_data8 = 8'h5A;
    for (int s = 0; s < stall; s++) begin
      acc_ready = 1'b0;
      #1;
      chk({nm, ".stall_valid"}, {av_m, av_w, av_s}, 3'b111);
      chk({nm, ".stall_data"}, $signed(ad_m), e32);
      chk({nm, ".stall_pres_ready"}, {pr_m, pr_w, pr_s}, 3'b000);
      chk({nm, ".stall_done"}, {done_m, done_w, done_s}, 3'b000);
      @(posedge clk); @(negedge clk);
    end
    acc_ready = 1'b1;
    start     = hold;
    #1;
    chk({nm, ".valid"}, {av_m, av_w, av_s}, 3'b111);
    chk({nm, ".pres_ready"}, {pr_m, pr_w, pr_s}, 3'b000);
    chk({nm, ".data32"}, $signed(ad_m), e32);
    chk({nm, ".ovf32"}, ovf_m, o32);
    chk({nm, ".data8w"}, $signed(ad_w), e8w);
    chk({nm, ".ovf8w"}, ovf_w, o8w);
    chk({nm, ".data8s"}, $signed(ad_s), e8s);
    chk({nm, ".ovf8s"}, ovf_s, o8s);
    chk({nm, ".done"}, {done_m, done_w, done_s}, 3'b111);
    if (hold) chk({nm, ".start_ready_in_output"}, sr_m, 0);
    @(posedge clk); @(negedge clk);
    acc_ready  = 1'b0;
    pres_valid = 1'b0;
    #1;
    check_idle({nm, ".after"});
  endtask

  initial begin
    longint e32, e8w, e8s;
    bit o32, o8w, o8s;
    int len;
    bit big;

    rst = 1'b1; clear = 1'b0; start = 1'b0; pres_valid = 1'b0; acc_ready = 1'b0;
    len_in = 16'd0; pres_data = 24'd0; pres_data8 = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_idle("reset");
    chk("reset.ovf", {ovf_m, ovf_w, ovf_s}, 3'b000);
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = '{4, '{10, -3, 7, 100},     0, 0, 0,  114, 0,  114, 0,  114, 0};
    vecs[1] = '{4, '{10, -3, 7, 100},     1, 5, 0,  114, 0,  114, 0,  114, 0};
    vecs[2] = '{0, '{0, 0, 0, 0},         0, 2, 0,    0, 0,    0, 0,    0, 0};
    vecs[3] = '{2, '{127, 1, 0, 0},       0, 1, 1,  128, 0, -128, 1,  127, 1};
    vecs[4] = '{2, '{1, 1, 0, 0},         0, 0, 0,    2, 0,    2, 0,    2, 0};
    vecs[5] = '{3, '{-128, -1, 5, 0},     1, 0, 0, -124, 0, -124, 1, -123, 1};
    vecs[6] = '{4, '{100, 100, -100, -100}, 0, 3, 0,  0, 0,    0, 1,  -73, 1};

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 4; i++) beats[i] = 24'(vecs[v].d[i]);
      job(vecs[v].len, vecs[v].gap, vecs[v].stall, vecs[v].hold,
          vecs[v].e32, vecs[v].o32, vecs[v].e8w, vecs[v].o8w, vecs[v].e8s, vecs[v].o8s,
          $sformatf("vec%0d", v));
    end

    // Abort after two of four beats, then a fresh single-beat job.
    start = 1'b1; len_in = 16'd4;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pres_valid = 1'b1; pres_data = 24'(i + 3); pres_data8 = 8'(i + 3);
      #1;
      chk("clear.pres_ready", pr_m, 1);
      @(posedge clk); @(negedge clk);
    end
    clear = 1'b1; pres_valid = 1'b1; acc_ready = 1'b1;
    #1;
    chk("clear.no_take", {pr_m, pr_w, pr_s}, 3'b000);
    chk("clear.no_done", {done_m, done_w, done_s}, 3'b000);
    @(posedge clk); @(negedge clk);
    clear = 1'b0; pres_valid = 1'b0; acc_ready = 1'b0;
    #1;
    check_idle("clear");
    chk("clear.ovf", {ovf_m, ovf_w, ovf_s}, 3'b000);
    beats[0] = -24'sd5;
    job(1, 0, 0, 0, -5, 0, -5, 0, -5, 0, "after_clear");

    // Random jobs against the reference model; every sixth job is long and large to overflow 32 bits.
    for (int j = 0; j < 24; j++) begin
      big = (j % 6 == 5);
      len = big ? $urandom_range(300, 260) : $urandom_range(12, 0);
      for (int i = 0; i < len; i++)
        beats[i] = big ? 24'sh7FFF00 + 24'($urandom_range(255, 0)) : 24'($urandom);
      model(32, 1'b0, len, e32, o32);
      model(8,  1'b0, len, e8w, o8w);
      model(8,  1'b1, len, e8s, o8s);
      job(len, 1'($urandom % 2), $urandom_range(3, 0), 1'b0,
          e32, o32, e8w, o8w, e8s, o8s, $sformatf("rnd%0d", j));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
